l2_write_buffer: RTL and testbench

- Single-entry write-back line buffer between the cache arbiter's L2-side port and the L2 cache.
- Absorbs 256-bit dcache writebacks and acks them in 1 cycle.
- Drains the held line to L2 when the upstream side is quiet.
- Passes reads through to L2, and services reads that hit the buffered line locally.

---
 rtl/l2_wbuf_pkg.sv | 33 +++
 rtl/l2_write_buffer_if.sv | 23 ++
 rtl/l2_wbuf_entry.sv | 42 ++++
 rtl/l2_write_buffer.sv | 129 ++++++++++++
 tb/tb_l2_write_buffer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_wbuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_wbuf_pkg
//  Description : Shared widths, FSM state type and address helpers for the
//                single-entry L2 write-back buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package l2_wbuf_pkg;

  localparam int ADDR_BITS   = 32;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_BITS    = ADDR_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } wbuf_state_t;

  // Line tag of a byte address.
  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr);
    return addr[ADDR_BITS-1:OFFSET_BITS];
  endfunction

  // Line-aligned byte address for a tag (offset bits forced to zero).
  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [TAG_BITS-1:0] tag);
    return {tag, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : l2_write_buffer_if
//  Description : Line-wide memory request/response bus. The master issues a
//                held read or write request, the slave answers with a
//                one-cycle resp pulse (and rdata for reads).
//  Revision    : 1.0 - initial release
// ============================================================================
interface l2_write_buffer_if;
  import l2_wbuf_pkg::*;

  logic                 read;
  logic                 write;
  logic [ADDR_BITS-1:0] address;
  logic [LINE_BITS-1:0] wdata;
  logic [LINE_BITS-1:0] rdata;
  logic                 resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);

endinterface
`default_nettype wire

// File: rtl/l2_wbuf_entry.sv
`default_nettype none
// ============================================================================
//  Module      : l2_wbuf_entry
//  Description : The single buffered line: valid/tag/data registers with
//                load and clear strobes and a combinational tag compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_wbuf_entry
  import l2_wbuf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [TAG_BITS-1:0]  load_tag,
  input  logic [LINE_BITS-1:0] load_data,
  input  logic [TAG_BITS-1:0]  cmp_tag,
  output logic                 valid,
  output logic [TAG_BITS-1:0]  tag,
  output logic [LINE_BITS-1:0] data,
  output logic                 hit
);

  // Entry registers; a load always wins over a clear (FSM never asserts both).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (cmp_tag == tag);

endmodule
`default_nettype wire

// File: rtl/l2_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : l2_write_buffer
//  Description : Single-entry write-back line buffer between the cache
//                arbiter (up) and the L2 cache (dn). Writes are absorbed and
//                acked in one cycle, the line is drained to L2 when the
//                upstream side is idle, read misses pass through to L2.
//  Config      : L2_WBUF_FORWARD_EN - when defined, read hits on the buffered
//                line are answered from the buffer; when undefined, a read
//                hit first drains the line and then re-reads it from L2.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_write_buffer
  import l2_wbuf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  l2_write_buffer_if.slave   up,
  l2_write_buffer_if.master  dn
);

  wbuf_state_t          state;
  wbuf_state_t          state_next;

  logic                 buf_valid;
  logic [TAG_BITS-1:0]  buf_tag;
  logic [LINE_BITS-1:0] buf_data;
  logic                 hit;
  logic                 load;
  logic                 clear;
  logic [TAG_BITS-1:0]  up_tag;

  assign up_tag = addr_tag(up.address);

  l2_wbuf_entry u_entry (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .clear     (clear),
    .load_tag  (up_tag),
    .load_data (up.wdata),
    .cmp_tag   (up_tag),
    .valid     (buf_valid),
    .tag       (buf_tag),
    .data      (buf_data),
    .hit       (hit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and output muxing; all outputs are a function of the
  // registered state so reset forces every output low immediately.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear      = 1'b0;
    up.resp    = 1'b0;
    up.rdata   = '0;
    dn.read    = 1'b0;
    dn.write   = 1'b0;
    dn.address = '0;
    dn.wdata   = '0;

    case (state)
      IDLE: begin
        // A write wins over a simultaneous (illegal) read.
        if (up.write) begin
          if (!buf_valid || hit) begin
            load       = 1'b1;
            state_next = ACK;
          end else begin
            // Different line buffered: flush it first, write stays pending.
            state_next = DRAIN;
          end
        end else if (up.read) begin
          if (hit) begin
`ifdef L2_WBUF_FORWARD_EN
            state_next = ACK;
`else
            state_next = DRAIN;
`endif
          end else begin
            state_next = READ;
          end
        end else if (buf_valid) begin
          state_next = DRAIN;
        end
      end

      ACK: begin
        // Write ack or forwarded read hit; rdata only matters for the latter.
        up.resp    = 1'b1;
        up.rdata   = buf_data;
        state_next = IDLE;
      end

      READ: begin
        dn.read    = 1'b1;
        dn.address = line_addr(up_tag);
        if (dn.resp) begin
          up.resp    = 1'b1;
          up.rdata   = dn.rdata;
          state_next = IDLE;
        end
      end

      DRAIN: begin
        dn.write   = 1'b1;
        dn.address = line_addr(buf_tag);
        dn.wdata   = buf_data;
        if (dn.resp) begin
          clear      = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_write_buffer
//  Description : Self-checking bench for l2_write_buffer: table of simple
//                transactions plus hand-written multi-cycle sequences, with
//                a scoreboard of expected L2 transactions and upstream data.
//  Config      : L2_WBUF_FORWARD_EN selects the expected read-hit behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_write_buffer;
  import l2_wbuf_pkg::*;

  logic clk = 1'b0;
  logic rst;

  l2_write_buffer_if up_bus ();
  l2_write_buffer_if dn_bus ();

  l2_write_buffer dut (
    .clk (clk),
    .rst (rst),
    .up  (up_bus),
    .dn  (dn_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit                   wr;
    logic [ADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0] data;
  } dn_txn_t;

  typedef struct {
    bit                   chk;
    logic [LINE_BITS-1:0] d;
  } up_exp_t;

  typedef struct {
    bit                   wr;
    logic [ADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0] data;
    int                   lat;
  } vec_t;

  dn_txn_t              exp_dn[$];
  up_exp_t              exp_up[$];
  int                   l2_lat   = 1;
  logic [LINE_BITS-1:0] l2_rdata = '0;
  logic                 prev_resp = 1'b0;

  task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                       input logic [LINE_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_dn(input bit wr, input logic [ADDR_BITS-1:0] addr,
                         input logic [LINE_BITS-1:0] data);
    dn_txn_t t;
    t.wr   = wr;
    t.addr = addr;
    t.data = data;
    exp_dn.push_back(t);
  endtask

  // Compare the L2 transaction being completed against the scoreboard.
  task automatic score_dn();
    dn_txn_t e;
    if (exp_dn.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL dn_unexpected: got write=%0b address=%h, required no L2 transaction",
               dn_bus.write, dn_bus.address);
    end else begin
      e = exp_dn.pop_front();
      check("dn_is_write", LINE_BITS'(dn_bus.write), LINE_BITS'(e.wr));
      check("dn_address", LINE_BITS'(dn_bus.address), LINE_BITS'(e.addr));
      if (e.wr) check("dn_wdata", dn_bus.wdata, e.data);
    end
  endtask

  // L2 model: answers each request after l2_lat cycles of it being held.
  initial begin
    int cnt;
    cnt = 0;
    dn_bus.resp  = 1'b0;
    dn_bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      dn_bus.resp = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (dn_bus.read || dn_bus.write) begin
        cnt++;
        if (cnt >= l2_lat) begin
          cnt          = 0;
          dn_bus.resp  = 1'b1;
          dn_bus.rdata = l2_rdata;
          score_dn();
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Bus invariants: no simultaneous L2 read/write, up_resp is a single pulse.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ((dn_bus.read && dn_bus.write) || (prev_resp && up_bus.resp)) begin
        n_fail++;
        $display("FAIL bus_monitor: got dn_read=%0b dn_write=%0b resp_pair=%0b, required no overlap",
                 dn_bus.read, dn_bus.write, prev_resp && up_bus.resp);
      end
    end
    prev_resp <= up_bus.resp;
  end

  // Issue one upstream request, wait for resp, check latency/data/L2 state.
  task automatic up_req(input bit wr, input logic [ADDR_BITS-1:0] addr,
                        input logic [LINE_BITS-1:0] wdata,
                        input logic [LINE_BITS-1:0] exp_rdata,
                        input bit exp_dn_read, input int exp_cyc,
                        input string name);
    up_exp_t e;
    int      cyc;
    bit      got;
    e.chk = !wr;
    e.d   = exp_rdata;
    exp_up.push_back(e);
    up_bus.write   = wr;
    up_bus.read    = !wr;
    up_bus.address = addr;
    up_bus.wdata   = wdata;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (up_bus.resp) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no up_resp in %0d cycles, required one", name, cyc);
      void'(exp_up.pop_front());
    end else begin
      e = exp_up.pop_front();
      check({name, "_latency"}, LINE_BITS'(cyc), LINE_BITS'(exp_cyc));
      if (e.chk) check({name, "_rdata"}, up_bus.rdata, e.d);
      check({name, "_dn_read"}, LINE_BITS'(dn_bus.read), LINE_BITS'(exp_dn_read));
      check({name, "_dn_write"}, LINE_BITS'(dn_bus.write), '0);
    end
    @(posedge clk);
    #1;
    up_bus.read  = 1'b0;
    up_bus.write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_up_resp"}, LINE_BITS'(up_bus.resp), '0);
    check({tag, "_up_rdata"}, up_bus.rdata, '0);
    check({tag, "_dn_read"}, LINE_BITS'(dn_bus.read), '0);
    check({tag, "_dn_write"}, LINE_BITS'(dn_bus.write), '0);
    check({tag, "_dn_address"}, LINE_BITS'(dn_bus.address), '0);
    check({tag, "_dn_wdata"}, dn_bus.wdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t                 vecs[6];
    logic [LINE_BITS-1:0] pat_a, pat_b, pat_c, pat_d, pat_e;
    logic [ADDR_BITS-1:0] aligned;
    int                   wcount;

    vecs[0] = '{1'b1, 32'h0000_1040, {32{8'hA5}}, 2};
    vecs[1] = '{1'b0, 32'h0000_1040, {8{32'h1111_2222}}, 1};
    vecs[2] = '{1'b0, 32'h0000_3000, {8{32'hDEAD_BEEF}}, 4};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, {16{16'h3C96}}, 1};
    vecs[4] = '{1'b0, 32'hFFFF_FFE4, {4{64'h0123_4567_89AB_CDEF}}, 3};
    vecs[5] = '{1'b1, 32'h0000_001F, {32{8'h5A}}, 5};

    pat_a = {8{32'hCAFE_F00D}};
    pat_b = {8{32'h0BAD_1DEA}};
    pat_c = {8{32'h7777_0001}};
    pat_d = {8{32'h4242_9999}};
    pat_e = {8{32'hFEED_FACE}};

    rst            = 1'b1;
    up_bus.read    = 1'b0;
    up_bus.write   = 1'b0;
    up_bus.address = '0;
    up_bus.wdata   = '0;

    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset");
    @(posedge clk);
    #1;

    // Table: isolated writes (acked, then drained) and read misses.
    for (int i = 0; i < 6; i++) begin
      l2_lat  = vecs[i].lat;
      aligned = vecs[i].addr & ~32'h1F;
      if (vecs[i].wr) begin
        push_dn(1'b1, aligned, vecs[i].data);
        up_req(1'b1, vecs[i].addr, vecs[i].data, '0, 1'b0, 2, $sformatf("vec%0d", i));
      end else begin
        l2_rdata = vecs[i].data;
        push_dn(1'b0, aligned, '0);
        up_req(1'b0, vecs[i].addr, '0, vecs[i].data, 1'b1, 1 + vecs[i].lat,
               $sformatf("vec%0d", i));
      end
      idle(vecs[i].lat + 4);
      check($sformatf("vec%0d_dn_pending", i), LINE_BITS'(exp_dn.size()), '0);
    end

    // Read hit on a freshly written line.
    l2_lat = 2;
    push_dn(1'b1, 32'h0000_1040, pat_a);
    up_req(1'b1, 32'h0000_1040, pat_a, '0, 1'b0, 2, "fwd_write");
`ifdef L2_WBUF_FORWARD_EN
    up_req(1'b0, 32'h0000_1044, '0, pat_a, 1'b0, 2, "fwd_read");
`else
    push_dn(1'b0, 32'h0000_1040, '0);
    l2_rdata = pat_a;
    up_req(1'b0, 32'h0000_1044, '0, pat_a, 1'b1, 6, "fwd_read");
`endif
    idle(8);
    check("fwd_dn_pending", LINE_BITS'(exp_dn.size()), '0);

    // Write to a different line while one is buffered.
    l2_lat = 3;
    push_dn(1'b1, 32'h0000_1040, pat_b);
    up_req(1'b1, 32'h0000_1040, pat_b, '0, 1'b0, 2, "conflict_first");
    push_dn(1'b1, 32'h0000_2080, pat_c);
    up_req(1'b1, 32'h0000_2080, pat_c, '0, 1'b0, 6, "conflict_second");
    idle(10);
    check("conflict_dn_pending", LINE_BITS'(exp_dn.size()), '0);

    // Back-to-back writes to one line: one drain carrying the newer data.
    l2_lat = 2;
    push_dn(1'b1, 32'h0000_1040, pat_d);
    up_req(1'b1, 32'h0000_1040, pat_b, '0, 1'b0, 2, "merge_first");
    up_req(1'b1, 32'h0000_1040, pat_d, '0, 1'b0, 2, "merge_second");
    idle(8);
    check("merge_dn_pending", LINE_BITS'(exp_dn.size()), '0);

    // Reset in the middle of a drain drops the line.
    l2_lat = 20;
    up_req(1'b1, 32'h0000_1040, pat_e, '0, 1'b0, 2, "rst_write");
    idle(2);
    check("rst_drain_started", LINE_BITS'(dn_bus.write), LINE_BITS'(1));
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_drain_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (dn_bus.write) wcount++;
    end
    check("rst_no_drain", LINE_BITS'(wcount), '0);
    @(posedge clk);
    #1;
    l2_lat   = 2;
    l2_rdata = pat_c;
    push_dn(1'b0, 32'h0000_1040, '0);
    up_req(1'b0, 32'h0000_1040, '0, pat_c, 1'b1, 3, "rst_read_back");
    idle(4);
    check("rst_dn_pending", LINE_BITS'(exp_dn.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
